// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared types for the mem_arbiter block.
//   arb_state_t : arbiter FSM states (round-robin / locked aux burst)
//   owner_t     : which master owns a RAM transfer or a returning read
package mem_arb_pkg;

    typedef enum logic {S_RR, S_BURST} arb_state_t;
    typedef enum logic {OWN_CPU, OWN_AUX} owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the cpu port, the aux port and the RAM command
// bus around mem_arbiter.
//   cpu_*  : cpu load/store port (req/we/addr/wdata in, gnt/rvalid/rdata out)
//   aux_*  : aux port, same as cpu plus aux_lock (burst lock request)
//   ram_*  : single-port RAM command (addr/we/wdata out, rdata in)
// modport slave  : the arbiter side
// modport master : the requesters + RAM side
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              aux_req;
    logic              aux_we;
    logic [ADDR_W-1:0] aux_addr;
    logic [DATA_W-1:0] aux_wdata;
    logic              aux_lock;
    logic              aux_gnt;
    logic              aux_rvalid;
    logic [DATA_W-1:0] aux_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  aux_req, aux_we, aux_addr, aux_wdata, aux_lock,
        input  ram_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output aux_gnt, aux_rvalid, aux_rdata,
        output ram_addr, ram_we, ram_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output aux_req, aux_we, aux_addr, aux_wdata, aux_lock,
        output ram_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  aux_gnt, aux_rvalid, aux_rdata,
        input  ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/mem_arbiter_rd_return_pipe.sv
// rd_return_pipe: RD_LAT-deep shift register tracking outstanding reads so
// the returning RAM word can be steered to the master that issued it.
//   clk, rst   : clock, asynchronous active-high clear of the valid bits
//   push_vld   : a read was granted this cycle
//   push_owner : master that owns that read
//   head_vld   : read data on ram_rdata is valid this cycle
//   head_owner : owner of the read at the pipe head
module rd_return_pipe
    import mem_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push_vld,
    input  owner_t push_owner,
    output logic   head_vld,
    output owner_t head_owner
);

    logic   vld_p   [RD_LAT];
    owner_t owner_p [RD_LAT];

    // Only the valid bits are cleared; a stale owner tag behind a cleared
    // valid is harmless, so the owner stages carry no reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) vld_p[i] <= 1'b0;
        end else begin
            vld_p[0] <= push_vld;
            for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    always_ff @(posedge clk) begin
        owner_p[0] <= push_owner;
        for (int i = 1; i < RD_LAT; i++) owner_p[i] <= owner_p[i-1];
    end

    assign head_vld   = vld_p[RD_LAT-1];
    assign head_owner = owner_p[RD_LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port data RAM between the cpu load/store
// port and the aux master. At most one transfer per cycle, round-robin on
// contention, optional locked aux bursts of up to MAX_BURST beats, and read
// data steered back to the issuing port RD_LAT cycles after its grant.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mem_arbiter_if.slave (cpu port, aux port, RAM command bus)
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam int               CNT_W    = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam bit               BURST_EN = (MAX_BURST > 1);

    arb_state_t       state_q;
    owner_t           last_gnt_q;
    logic [CNT_W-1:0] burst_cnt_q;

    logic   cpu_gnt;
    logic   aux_gnt;
    logic   push_vld;
    owner_t push_owner;
    logic   head_vld;
    owner_t head_owner;

    // Grant decision. Forced low during reset so nothing reaches the RAM.
    always_comb begin
        cpu_gnt = 1'b0;
        aux_gnt = 1'b0;
        if (!rst) begin
            if (state_q == S_BURST) begin
                aux_gnt = bus.aux_req;
                cpu_gnt = bus.cpu_req && !bus.aux_req;
            end else if (bus.cpu_req && bus.aux_req) begin
                cpu_gnt = (last_gnt_q == OWN_AUX);
                aux_gnt = (last_gnt_q == OWN_CPU);
            end else begin
                cpu_gnt = bus.cpu_req;
                aux_gnt = bus.aux_req;
            end
        end
    end

    // Any burst exit (lock dropped, aux idle, or length cap) leaves
    // last_gnt at AUX, even if cpu took the exit cycle, so cpu wins the
    // next contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_RR;
            last_gnt_q  <= OWN_AUX;
            burst_cnt_q <= '0;
        end else begin
            case (state_q)
                S_RR: begin
                    if (cpu_gnt) begin
                        last_gnt_q <= OWN_CPU;
                    end else if (aux_gnt) begin
                        last_gnt_q <= OWN_AUX;
                        if (bus.aux_lock && BURST_EN) begin
                            state_q     <= S_BURST;
                            burst_cnt_q <= CNT_W'(1);
                        end
                    end
                end
                S_BURST: begin
                    if (aux_gnt && bus.aux_lock && burst_cnt_q != CNT_LAST) begin
                        burst_cnt_q <= burst_cnt_q + CNT_W'(1);
                    end else begin
                        state_q     <= S_RR;
                        burst_cnt_q <= '0;
                        last_gnt_q  <= OWN_AUX;
                    end
                end
                default: state_q <= S_RR;
            endcase
        end
    end

    // RAM command mux: idle bus is all zeros.
    always_comb begin
        bus.ram_we    = 1'b0;
        bus.ram_addr  = {ADDR_W{1'b0}};
        bus.ram_wdata = {DATA_W{1'b0}};
        if (cpu_gnt) begin
            bus.ram_we    = bus.cpu_we;
            bus.ram_addr  = bus.cpu_addr;
            bus.ram_wdata = bus.cpu_wdata;
        end else if (aux_gnt) begin
            bus.ram_we    = bus.aux_we;
            bus.ram_addr  = bus.aux_addr;
            bus.ram_wdata = bus.aux_wdata;
        end
    end

    assign push_vld   = (cpu_gnt && !bus.cpu_we) || (aux_gnt && !bus.aux_we);
    assign push_owner = aux_gnt ? OWN_AUX : OWN_CPU;

    // Grant cycle -> RD_LAT cycles later: read return.
    rd_return_pipe #(
        .RD_LAT (RD_LAT)
    ) u_ret (
        .clk        (clk),
        .rst        (rst),
        .push_vld   (push_vld),
        .push_owner (push_owner),
        .head_vld   (head_vld),
        .head_owner (head_owner)
    );

    assign bus.cpu_gnt    = cpu_gnt;
    assign bus.aux_gnt    = aux_gnt;
    assign bus.cpu_rvalid = head_vld && (head_owner == OWN_CPU);
    assign bus.aux_rvalid = head_vld && (head_owner == OWN_AUX);
    assign bus.cpu_rdata  = bus.ram_rdata;
    assign bus.aux_rdata  = bus.ram_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. Two instances share the
// same request stimulus: dut1 with RD_LAT=1, dut2 with RD_LAT=2, both with
// MAX_BURST=8. Grant/RAM-bus expectations are checked per step; expected
// read returns are queued at issue time and consumed by a monitor whenever
// an rvalid appears.
module tb_mem_arbiter;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 8;

    // Expected aux grants per step (1 = aux, 0 = cpu), first step leftmost.
    localparam logic [0:13] B_AUX  = 14'b11111111011110;
    localparam logic [0:5]  C_AUX  = 6'b110010;
    localparam logic [0:5]  C_REQ  = 6'b110111;
    localparam logic [0:5]  C_LOCK = 6'b110000;

    typedef struct packed {
        logic        own_aux;
        logic [31:0] data;
        int          due;
    } ret_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              mem_init;
    logic              cpu_req, cpu_we, aux_req, aux_we, aux_lock;
    logic [ADDR_W-1:0] cpu_addr, aux_addr;
    logic [DATA_W-1:0] cpu_wdata, aux_wdata;

    int   cyc;
    int   checks;
    int   errors;
    ret_t q1[$];
    ret_t q2[$];
    logic [31:0] model [256];

    logic [31:0] mem1 [256];
    logic [31:0] mem2 [256];
    logic [31:0] rd1_p0, rd2_p0, rd2_p1;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();
    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus2 ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1), .MAX_BURST(MAX_BURST))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));
    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(2), .MAX_BURST(MAX_BURST))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    assign bus1.cpu_req   = cpu_req;    assign bus2.cpu_req   = cpu_req;
    assign bus1.cpu_we    = cpu_we;     assign bus2.cpu_we    = cpu_we;
    assign bus1.cpu_addr  = cpu_addr;   assign bus2.cpu_addr  = cpu_addr;
    assign bus1.cpu_wdata = cpu_wdata;  assign bus2.cpu_wdata = cpu_wdata;
    assign bus1.aux_req   = aux_req;    assign bus2.aux_req   = aux_req;
    assign bus1.aux_we    = aux_we;     assign bus2.aux_we    = aux_we;
    assign bus1.aux_addr  = aux_addr;   assign bus2.aux_addr  = aux_addr;
    assign bus1.aux_wdata = aux_wdata;  assign bus2.aux_wdata = aux_wdata;
    assign bus1.aux_lock  = aux_lock;   assign bus2.aux_lock  = aux_lock;
    assign bus1.ram_rdata = rd1_p0;
    assign bus2.ram_rdata = rd2_p1;

    function automatic logic [31:0] pat(input int a);
        return 32'hA500_0000 | 32'(a);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // RAM models: 256 words, read latency 1 (mem1) and 2 (mem2).
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) begin
                mem1[i] <= pat(i);
                mem2[i] <= pat(i);
            end
        end else begin
            if (bus1.ram_we) mem1[bus1.ram_addr[7:0]] <= bus1.ram_wdata;
            if (bus2.ram_we) mem2[bus2.ram_addr[7:0]] <= bus2.ram_wdata;
        end
        rd1_p0 <= mem1[bus1.ram_addr[7:0]];
        rd2_p0 <= mem2[bus2.ram_addr[7:0]];
        rd2_p1 <= rd2_p0;
    end

    task automatic push_ret(input logic own_aux, input logic [31:0] d);
        ret_t e;
        e.own_aux = own_aux;
        e.data    = d;
        e.due     = cyc + 1;
        q1.push_back(e);
        e.due     = cyc + 2;
        q2.push_back(e);
    endtask

    task automatic chk_ret(input int k, input logic cv, input logic av,
                           input logic [31:0] cd, input logic [31:0] ad);
        ret_t        e;
        bit          have;
        logic [31:0] got;
        have = 1'b0;
        e    = '0;
        if (cv || av) begin
            checks++;
            got = av ? ad : cd;
            if (k == 0 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            if (k == 1 && q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
            if (!have) begin
                errors++;
                $display("FAIL ret_dut%0d unexpected: cpu_rvalid=%b aux_rvalid=%b cycle %0d, want no rvalid",
                         k + 1, cv, av, cyc);
            end else if ((cv && av) || av != e.own_aux || got !== e.data || cyc != e.due) begin
                errors++;
                $display("FAIL ret_dut%0d: got cpu/aux=%b%b data=%h cycle %0d, want aux=%b data=%h cycle %0d",
                         k + 1, cv, av, got, cyc, e.own_aux, e.data, e.due);
            end
        end
        if (k == 0 && q1.size() > 0 && q1[0].due <= cyc) begin
            e = q1.pop_front();
            checks++; errors++;
            $display("FAIL ret_dut1 missing: no rvalid by cycle %0d, want aux=%b data=%h", cyc, e.own_aux, e.data);
        end
        if (k == 1 && q2.size() > 0 && q2[0].due <= cyc) begin
            e = q2.pop_front();
            checks++; errors++;
            $display("FAIL ret_dut2 missing: no rvalid by cycle %0d, want aux=%b data=%h", cyc, e.own_aux, e.data);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            chk_ret(0, bus1.cpu_rvalid, bus1.aux_rvalid, bus1.cpu_rdata, bus1.aux_rdata);
            chk_ret(1, bus2.cpu_rvalid, bus2.aux_rvalid, bus2.cpu_rdata, bus2.aux_rdata);
        end
    endtask

    // One cycle of stimulus: inputs are already set; ec/ea are the expected
    // grants. keep=0 means the read must never return (reset follows).
    task automatic step(input logic ec, input logic ea, input logic keep, input string tag);
        logic              exp_we;
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_wd;
        exp_we   = (ec && cpu_we) || (ea && aux_we);
        exp_addr = ec ? cpu_addr  : (ea ? aux_addr  : '0);
        exp_wd   = ec ? cpu_wdata : (ea ? aux_wdata : '0);
        @(negedge clk);
        checks++;
        if ({bus1.cpu_gnt, bus1.aux_gnt, bus2.cpu_gnt, bus2.aux_gnt} !== {ec, ea, ec, ea}) begin
            errors++;
            $display("FAIL %s gnt: got dut1 cpu/aux=%b%b dut2 cpu/aux=%b%b, want %b%b",
                     tag, bus1.cpu_gnt, bus1.aux_gnt, bus2.cpu_gnt, bus2.aux_gnt, ec, ea);
        end
        checks++;
        if ({bus1.ram_we, bus1.ram_addr, bus1.ram_wdata} !== {exp_we, exp_addr, exp_wd} ||
            {bus2.ram_we, bus2.ram_addr, bus2.ram_wdata} !== {exp_we, exp_addr, exp_wd}) begin
            errors++;
            $display("FAIL %s ram: got dut1 we=%b a=%h d=%h dut2 we=%b a=%h d=%h, want we=%b a=%h d=%h",
                     tag, bus1.ram_we, bus1.ram_addr, bus1.ram_wdata,
                     bus2.ram_we, bus2.ram_addr, bus2.ram_wdata, exp_we, exp_addr, exp_wd);
        end
        if (keep && ec && !cpu_we) push_ret(1'b0, model[cpu_addr[7:0]]);
        if (keep && ea && !aux_we) push_ret(1'b1, model[aux_addr[7:0]]);
        if (ec && cpu_we) model[cpu_addr[7:0]] = cpu_wdata;
        if (ea && aux_we) model[aux_addr[7:0]] = aux_wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_check(input string tag);
        @(negedge clk);
        checks++;
        if ({bus1.cpu_gnt, bus1.aux_gnt, bus1.ram_we, bus1.cpu_rvalid, bus1.aux_rvalid,
             bus2.cpu_gnt, bus2.aux_gnt, bus2.ram_we, bus2.cpu_rvalid, bus2.aux_rvalid} !== 10'b0) begin
            errors++;
            $display("FAIL %s: got dut1 gnt=%b%b we=%b rv=%b%b dut2 gnt=%b%b we=%b rv=%b%b, want all 0",
                     tag, bus1.cpu_gnt, bus1.aux_gnt, bus1.ram_we, bus1.cpu_rvalid, bus1.aux_rvalid,
                     bus2.cpu_gnt, bus2.aux_gnt, bus2.ram_we, bus2.cpu_rvalid, bus2.aux_rvalid);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int beat;
        rst = 1'b1;  mem_init = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        aux_req = 1'b0; aux_we = 1'b0; aux_addr = '0; aux_wdata = '0; aux_lock = 1'b0;
        checks = 0;  errors = 0;
        for (int i = 0; i < 256; i++) model[i] = pat(i);
        fork
            monitor();
        join_none

        repeat (2) @(posedge clk);
        #1;
        mem_init = 1'b0;

        // Reset holds every grant and return low even with both requesting.
        cpu_req = 1'b1; aux_req = 1'b1;
        cpu_addr = 16'h0003; aux_addr = 16'h0007;
        reset_check("rst_hold");
        rst = 1'b0;

        // Contending reads alternate, cpu first.
        step(1'b1, 1'b0, 1'b1, "rr0");
        step(1'b0, 1'b1, 1'b1, "rr1");
        step(1'b1, 1'b0, 1'b1, "rr2");
        step(1'b0, 1'b1, 1'b1, "rr3");

        // cpu write then read-back of the same word.
        aux_req = 1'b0;
        cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 32'hDEAD_BEEF;
        step(1'b1, 1'b0, 1'b1, "cpu_wr");
        cpu_we = 1'b0; cpu_wdata = '0;
        step(1'b1, 1'b0, 1'b1, "cpu_rd");
        cpu_req = 1'b0;
        step(1'b0, 1'b0, 1'b1, "idle0");

        // 12-beat locked aux write burst against a constantly requesting cpu.
        cpu_req = 1'b1; cpu_addr = 16'h0020;
        aux_we = 1'b1;
        beat = 0;
        for (int i = 0; i < 14; i++) begin
            aux_req   = (beat < 12);
            aux_lock  = (beat < 11);
            aux_addr  = 16'h0040 + 16'(beat);
            aux_wdata = 32'h0000_1000 + 32'(beat);
            step(!B_AUX[i], B_AUX[i], 1'b1, "burst");
            if (B_AUX[i]) beat++;
        end

        // Locked aux reads; aux drops req for one cycle inside the burst.
        cpu_addr = 16'h0010;
        aux_we = 1'b0; aux_wdata = '0;
        beat = 0;
        for (int i = 0; i < 6; i++) begin
            aux_req  = C_REQ[i];
            aux_lock = C_LOCK[i];
            aux_addr = 16'h0041 + 16'(beat);
            step(!C_AUX[i], C_AUX[i], 1'b1, "burst_drop");
            if (C_AUX[i]) beat++;
        end
        cpu_req = 1'b0; aux_req = 1'b0; aux_lock = 1'b0;
        repeat (3) step(1'b0, 1'b0, 1'b1, "idle1");

        // aux read in flight when reset pulses: it must never return.
        aux_req = 1'b1; aux_addr = 16'h0005;
        step(1'b0, 1'b1, 1'b0, "pre_rst");
        rst = 1'b1;
        cpu_req = 1'b1; cpu_addr = 16'h0006;
        reset_check("rst_mid");
        rst = 1'b0;
        step(1'b1, 1'b0, 1'b1, "post_rst0");
        step(1'b0, 1'b1, 1'b1, "post_rst1");
        cpu_req = 1'b0; aux_req = 1'b0;
        repeat (4) step(1'b0, 1'b0, 1'b1, "drain");

        checks++;
        if (q1.size() != 0 || q2.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d reads outstanding, want 0/0", q1.size(), q2.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single-port data RAM between the `cpu` datapath (load/store port: ALU result as address, register-file read data as store data) and an auxiliary master `aux` (program loader / display reader). Grants at most one transfer per cycle. Supports locked `aux` bursts with a bounded length. Returns read data to the owning port after a fixed RAM latency.

## Interface
Parameters:
- `ADDR_W`, 16: RAM word-address width.
- `DATA_W`, 32: data width.
- `RD_LAT`, 1: RAM read latency in cycles; legal values 1–2.
- `MAX_BURST`, 8: maximum consecutive locked `aux` beats; must be ≥1.

Ports:
- `clk`  in  1  sole clock; all state is updated on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cpu_req`  in  1  cpu requests a transfer.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  ADDR_W  word address.
- `cpu_wdata`  in  DATA_W  store data.
- `cpu_gnt`  out  1  transfer accepted this cycle (combinational).
- `cpu_rvalid`  out  1  read data valid for cpu.
- `cpu_rdata`  out  DATA_W  read data.
- `aux_req`, `aux_we`, `aux_addr`, `aux_wdata`, `aux_gnt`, `aux_rvalid`, `aux_rdata`: same widths and meanings as the cpu set.
- `aux_lock`  in  1  aux requests a burst lock; sampled only while aux is granted.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_we`  out  1  RAM write enable.
- `ram_wdata`  out  DATA_W  RAM write data.
- `ram_rdata`  in  DATA_W  RAM read data, valid RD_LAT cycles after the address.

## Operation
- Transfer rule: a transfer occurs on port X in any cycle where `X_req && X_gnt`. A requester holds `we`/`addr`/`wdata` stable until it is granted.
- RAM command is a combinational mux of the granted port.
  - `ram_we = granted && we`.
  - When nothing is granted: `ram_we = 0`, `ram_addr = 0`, `ram_wdata = 0`.
- State machine, states `S_RR` and `S_BURST`. Registers: `last_gnt` (CPU/AUX) and `burst_cnt`.
- `S_RR`:
  - Only one port requesting: that port is granted.
  - Both requesting: the port ≠ `last_gnt` is granted.
  - Every grant updates `last_gnt`.
  - If aux is granted with `aux_lock = 1`: go to `S_BURST` with `burst_cnt = 1`.
- `S_BURST`:
  - aux has absolute priority. Each aux beat increments `burst_cnt`.
  - Exit to `S_RR` on any of:
    - the beat with `aux_lock = 0`;
    - a cycle with `aux_req = 0` (cpu is granted that same cycle if requesting);
    - the beat that makes `burst_cnt == MAX_BURST`.
  - On exit, `burst_cnt = 0` and `last_gnt = AUX`, so cpu wins the next contention.
  - `MAX_BURST = 1`: a locked grant never enters `S_BURST`.
- Read return: an RD_LAT-deep shift register of {valid, owner}.
  - An entry is pushed with valid = 1 and the owner's id on every granted read.
  - At the pipe head, `X_rvalid = valid && owner == X`.
  - Both `cpu_rdata` and `aux_rdata` are driven directly from `ram_rdata` (unconditional).
  - Writes push valid = 0.
- Width: `burst_cnt` is `$clog2(MAX_BURST+1)` bits and never exceeds `MAX_BURST`.

## Timing
- Reset (asynchronous, and mid-operation):
  - State → `S_RR`, `last_gnt = AUX`, `burst_cnt = 0`, return pipe cleared.
  - `cpu_gnt`, `aux_gnt`, `ram_we`, `cpu_rvalid`, `aux_rvalid` are all 0 while `rst` is high.
  - In-flight reads are dropped: no `rvalid` for them after reset is released.
- Grant latency: 0 cycles (same cycle as request when the port wins).
- Read latency: `X_rvalid` is asserted exactly RD_LAT cycles after the grant cycle.
- Throughput: one transfer per cycle. Back-to-back reads from alternating ports return in grant order.
- Simultaneous first requests after reset: cpu wins, because `last_gnt = AUX`.
- A request dropped before grant leaves no side effect.

## Structure
- Package `mem_arb_pkg`:
  - `typedef enum logic {S_RR, S_BURST} arb_state_t`
  - `typedef enum logic {OWN_CPU, OWN_AUX} owner_t`
- Sub-module `rd_return_pipe`: parameterised RD_LAT shift register of {valid, owner_t}, asynchronous clear on `rst`.
- The top level holds the FSM, the grant logic and the RAM mux.

## Test plan
- Both requesting reads from cycle 0, RD_LAT = 1, no lock → grants alternate cpu, aux, cpu, aux. `cpu_rvalid` appears 1 cycle after each cpu grant with the correct `ram_rdata` word.
- aux locked burst of 12 writes, cpu requesting throughout, MAX_BURST = 8 → 8 consecutive aux grants, then a cpu grant, then aux resumes.
- In `S_BURST`, aux drops `aux_req` for one cycle while cpu requests → cpu is granted that cycle and state returns to `S_RR`.
- cpu write to 0x0010 with 0xDEADBEEF, then cpu read of 0x0010 → `ram_we` = 1 for exactly one cycle. Read returns 0xDEADBEEF, `cpu_rvalid` is 1 and `aux_rvalid` stays 0.
- RD_LAT = 2, aux read granted, `rst` pulsed in the next cycle → no `aux_rvalid` ever asserts. After reset, simultaneous requests grant cpu first.
